// File: rtl/axi_mm_pipe_pkg.sv
// Shared definitions for the registered AXI-MM master channel packer.
// Contents: packed-word width functions, field widths and offsets,
// skid-buffer state enum and AXI response codes.
package axi_mm_pipe_pkg;

    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    // AR/AW field offsets, relative to the end of the ID field
    localparam int unsigned AX_SIZE_OFS  = 0;
    localparam int unsigned AX_LEN_OFS   = AX_SIZE_OFS + SIZE_W;
    localparam int unsigned AX_BURST_OFS = AX_LEN_OFS + LEN_W;
    localparam int unsigned AX_ADDR_OFS  = AX_BURST_OFS + BURST_W;

    // R field offsets, relative to the end of the data field
    localparam int unsigned R_LAST_OFS = 0;
    localparam int unsigned R_RESP_OFS = 1;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic int unsigned aw_pk_w(input int unsigned id_w, input int unsigned addr_w);
        return id_w + SIZE_W + LEN_W + BURST_W + addr_w;
    endfunction

    function automatic int unsigned w_pk_w(input int unsigned id_w, input int unsigned data_w);
        return id_w + data_w + data_w / 8 + 1;
    endfunction

    function automatic int unsigned r_pk_w(input int unsigned id_w, input int unsigned data_w);
        return id_w + data_w + 1 + RESP_W;
    endfunction

    function automatic int unsigned b_pk_w(input int unsigned id_w);
        return id_w + RESP_W;
    endfunction

endpackage

// File: rtl/axi_mm_skid_buf.sv
// Two-entry skid buffer with fully registered valid/ready.
// Ports: clk/rst_n (async active-low), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream, data from head register).
module axi_mm_skid_buf
    import axi_mm_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      r_state;
    skid_state_e      w_next;
    logic             r_alive;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head;
    logic             w_load_tail;
    logic             w_shift;

    // r_alive holds ready low while reset is asserted and for the first edge after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SKID_EMPTY;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SKID_EMPTY: if (w_push) w_next = SKID_ONE;
            SKID_ONE: begin
                if (w_push && !w_pop)      w_next = SKID_FULL;
                else if (w_pop && !w_push) w_next = SKID_EMPTY;
            end
            SKID_FULL:  if (w_pop) w_next = SKID_ONE;
            default:    w_next = SKID_EMPTY;
        endcase
    end

    always_comb begin
        in_ready    = r_alive && (r_state != SKID_FULL);
        out_valid   = (r_state != SKID_EMPTY);
        out_data    = r_head;
        w_push      = in_valid && in_ready;
        w_pop       = out_valid && out_ready;
        w_load_head = w_push && ((r_state == SKID_EMPTY) || ((r_state == SKID_ONE) && w_pop));
        w_load_tail = w_push && (r_state == SKID_ONE) && !w_pop;
        w_shift     = w_pop && (r_state == SKID_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_load_head)  r_head <= in_data;
            else if (w_shift) r_head <= r_tail;
            if (w_load_tail)  r_tail <= in_data;
        end
    end

endmodule

// File: rtl/axi_mm_master_name_pipe.sv
// Registered AXI-MM master channel packer: packs AR/AW/W into TX FIFO words,
// unpacks R/B RX FIFO words, each through a skid buffer, and limits
// outstanding read/write bursts.
// Ports: clk_wr/rst_wr_n (async active-low); user_ar*/aw*/w* AXI inputs;
//        user_r*/b* AXI outputs; user_{ar,aw,w}_vld + txfifo_*_data to TX FIFO;
//        user_{r,b}_vld + rxfifo_*_data from RX FIFO; rd_out_cnt/wr_out_cnt.
// Optional: AXI_MM_MASTER_RESP_ERR_CNT_EN adds rd_err_cnt/wr_err_cnt.
module axi_mm_master_name_pipe
    import axi_mm_pipe_pkg::*;
#(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MAX_RD_OUT = 16,
    parameter int unsigned MAX_WR_OUT = 16
) (
    input  logic                                 clk_wr,
    input  logic                                 rst_wr_n,
    input  logic [ID_W-1:0]                      user_arid,
    input  logic [2:0]                           user_arsize,
    input  logic [7:0]                           user_arlen,
    input  logic [1:0]                           user_arburst,
    input  logic [ADDR_W-1:0]                    user_araddr,
    input  logic                                 user_arvalid,
    output logic                                 user_arready,
    input  logic [ID_W-1:0]                      user_awid,
    input  logic [2:0]                           user_awsize,
    input  logic [7:0]                           user_awlen,
    input  logic [1:0]                           user_awburst,
    input  logic [ADDR_W-1:0]                    user_awaddr,
    input  logic                                 user_awvalid,
    output logic                                 user_awready,
    input  logic [ID_W-1:0]                      user_wid,
    input  logic [DATA_W-1:0]                    user_wdata,
    input  logic [DATA_W/8-1:0]                  user_wstrb,
    input  logic                                 user_wlast,
    input  logic                                 user_wvalid,
    output logic                                 user_wready,
    output logic [ID_W-1:0]                      user_rid,
    output logic [DATA_W-1:0]                    user_rdata,
    output logic                                 user_rlast,
    output logic [1:0]                           user_rresp,
    output logic                                 user_rvalid,
    input  logic                                 user_rready,
    output logic [ID_W-1:0]                      user_bid,
    output logic [1:0]                           user_bresp,
    output logic                                 user_bvalid,
    input  logic                                 user_bready,
    output logic                                 user_ar_vld,
    output logic [aw_pk_w(ID_W, ADDR_W)-1:0]     txfifo_ar_data,
    input  logic                                 user_ar_ready,
    output logic                                 user_aw_vld,
    output logic [aw_pk_w(ID_W, ADDR_W)-1:0]     txfifo_aw_data,
    input  logic                                 user_aw_ready,
    output logic                                 user_w_vld,
    output logic [w_pk_w(ID_W, DATA_W)-1:0]      txfifo_w_data,
    input  logic                                 user_w_ready,
    input  logic                                 user_r_vld,
    input  logic [r_pk_w(ID_W, DATA_W)-1:0]      rxfifo_r_data,
    output logic                                 user_r_ready,
    input  logic                                 user_b_vld,
    input  logic [b_pk_w(ID_W)-1:0]              rxfifo_b_data,
    output logic                                 user_b_ready,
`ifdef AXI_MM_MASTER_RESP_ERR_CNT_EN
    output logic [15:0]                          rd_err_cnt,
    output logic [15:0]                          wr_err_cnt,
`endif
    output logic [$clog2(MAX_RD_OUT+1)-1:0]      rd_out_cnt,
    output logic [$clog2(MAX_WR_OUT+1)-1:0]      wr_out_cnt
);

    localparam int unsigned AX_PK = aw_pk_w(ID_W, ADDR_W);
    localparam int unsigned W_PK  = w_pk_w(ID_W, DATA_W);
    localparam int unsigned R_PK  = r_pk_w(ID_W, DATA_W);
    localparam int unsigned B_PK  = b_pk_w(ID_W);
    localparam int unsigned RD_CW = $clog2(MAX_RD_OUT + 1);
    localparam int unsigned WR_CW = $clog2(MAX_WR_OUT + 1);
    localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUT);
    localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUT);
    localparam logic [RD_CW-1:0] RD_ONE = RD_CW'(1);
    localparam logic [WR_CW-1:0] WR_ONE = WR_CW'(1);

    logic [AX_PK-1:0] w_ar_pk;
    logic [AX_PK-1:0] w_aw_pk;
    logic [R_PK-1:0]  w_r_pk;
    logic [B_PK-1:0]  w_b_pk;
    logic             w_ar_in_ready;
    logic             w_aw_in_ready;
    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_rd_inc;
    logic             w_rd_dec;
    logic             w_wr_inc;
    logic             w_wr_dec;
    logic [RD_CW-1:0] r_rd_cnt;
    logic [WR_CW-1:0] r_wr_cnt;

    always_comb begin
        w_ar_pk = '0;
        w_ar_pk[ID_W-1:0]                       = user_arid;
        w_ar_pk[ID_W+AX_SIZE_OFS  +: SIZE_W]    = user_arsize;
        w_ar_pk[ID_W+AX_LEN_OFS   +: LEN_W]     = user_arlen;
        w_ar_pk[ID_W+AX_BURST_OFS +: BURST_W]   = user_arburst;
        w_ar_pk[ID_W+AX_ADDR_OFS  +: ADDR_W]    = user_araddr;
        w_aw_pk = '0;
        w_aw_pk[ID_W-1:0]                       = user_awid;
        w_aw_pk[ID_W+AX_SIZE_OFS  +: SIZE_W]    = user_awsize;
        w_aw_pk[ID_W+AX_LEN_OFS   +: LEN_W]     = user_awlen;
        w_aw_pk[ID_W+AX_BURST_OFS +: BURST_W]   = user_awburst;
        w_aw_pk[ID_W+AX_ADDR_OFS  +: ADDR_W]    = user_awaddr;
    end

    // Limiters use only registered counts, so ready outputs stay flop-driven
    assign w_rd_ok      = (r_rd_cnt < RD_MAX);
    assign w_wr_ok      = (r_wr_cnt < WR_MAX);
    assign user_arready = w_ar_in_ready && w_rd_ok;
    assign user_awready = w_aw_in_ready && w_wr_ok;

    axi_mm_skid_buf #(.WIDTH(AX_PK)) u_ar_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_arvalid && w_rd_ok), .in_ready(w_ar_in_ready), .in_data(w_ar_pk),
        .out_valid(user_ar_vld), .out_ready(user_ar_ready), .out_data(txfifo_ar_data)
    );

    axi_mm_skid_buf #(.WIDTH(AX_PK)) u_aw_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_awvalid && w_wr_ok), .in_ready(w_aw_in_ready), .in_data(w_aw_pk),
        .out_valid(user_aw_vld), .out_ready(user_aw_ready), .out_data(txfifo_aw_data)
    );

    axi_mm_skid_buf #(.WIDTH(W_PK)) u_w_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_wvalid), .in_ready(user_wready),
        .in_data({user_wlast, user_wstrb, user_wdata, user_wid}),
        .out_valid(user_w_vld), .out_ready(user_w_ready), .out_data(txfifo_w_data)
    );

    axi_mm_skid_buf #(.WIDTH(R_PK)) u_r_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_r_vld), .in_ready(user_r_ready), .in_data(rxfifo_r_data),
        .out_valid(user_rvalid), .out_ready(user_rready), .out_data(w_r_pk)
    );

    axi_mm_skid_buf #(.WIDTH(B_PK)) u_b_skid (
        .clk(clk_wr), .rst_n(rst_wr_n),
        .in_valid(user_b_vld), .in_ready(user_b_ready), .in_data(rxfifo_b_data),
        .out_valid(user_bvalid), .out_ready(user_bready), .out_data(w_b_pk)
    );

    assign user_rid   = w_r_pk[ID_W-1:0];
    assign user_rdata = w_r_pk[ID_W +: DATA_W];
    assign user_rlast = w_r_pk[ID_W+DATA_W+R_LAST_OFS];
    assign user_rresp = w_r_pk[ID_W+DATA_W+R_RESP_OFS +: RESP_W];
    assign user_bid   = w_b_pk[ID_W-1:0];
    assign user_bresp = w_b_pk[ID_W +: RESP_W];

    assign w_rd_inc = user_arvalid && user_arready;
    assign w_rd_dec = user_rvalid && user_rready && user_rlast;
    assign w_wr_inc = user_awvalid && user_awready;
    assign w_wr_dec = user_bvalid && user_bready;

    // Increment is already bounded by the ready gate; decrement at zero holds
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd_inc && !w_rd_dec)                       r_rd_cnt <= r_rd_cnt + RD_ONE;
            else if (w_rd_dec && !w_rd_inc && r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - RD_ONE;
            if (w_wr_inc && !w_wr_dec)                       r_wr_cnt <= r_wr_cnt + WR_ONE;
            else if (w_wr_dec && !w_wr_inc && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - WR_ONE;
        end
    end

    assign rd_out_cnt = r_rd_cnt;
    assign wr_out_cnt = r_wr_cnt;

`ifdef AXI_MM_MASTER_RESP_ERR_CNT_EN
    logic [15:0] r_rd_err;
    logic [15:0] r_wr_err;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_rd_err <= '0;
            r_wr_err <= '0;
        end else begin
            if (user_rvalid && user_rready && user_rresp[1] && r_rd_err != '1)
                r_rd_err <= r_rd_err + 16'd1;
            if (user_bvalid && user_bready && user_bresp[1] && r_wr_err != '1)
                r_wr_err <= r_wr_err + 16'd1;
        end
    end

    assign rd_err_cnt = r_rd_err;
    assign wr_err_cnt = r_wr_err;
`endif

endmodule
